// File: rtl/sevenseg_bcd_scan_counter.sv
// sevenseg_bcd_scan_counter
// Prescaled N-digit BCD event counter with a time-multiplexed 7-segment
// scan output, optional leading-zero blanking and run-time selectable
// common-anode / common-cathode drive polarity.
module sevenseg_bcd_scan_counter #(
  parameter int N_DIGITS = 4,
  parameter int TICK_DIV = 16,
  parameter int SCAN_DIV = 4,
  parameter int LZ_BLANK = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  cathod_anode,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic [4*N_DIGITS-1:0] count,
  output logic                  wrap
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] SCAN_MAX  = CW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SEL_MAX   = SW'(N_DIGITS - 1);

  // Segment font, bit order {g,f,e,d,c,b,a}, active high.
  function automatic logic [6:0] font(input logic [3:0] d);
    logic [6:0] f;
    case (d)
      4'd0:    f = 7'h3F;
      4'd1:    f = 7'h06;
      4'd2:    f = 7'h5B;
      4'd3:    f = 7'h4F;
      4'd4:    f = 7'h66;
      4'd5:    f = 7'h6D;
      4'd6:    f = 7'h7D;
      4'd7:    f = 7'h07;
      4'd8:    f = 7'h7F;
      4'd9:    f = 7'h6F;
      default: f = 7'h00;
    endcase
    return f;
  endfunction

  logic [PW-1:0]         presc_q, presc_d;
  logic [4*N_DIGITS-1:0] count_q, count_d;
  logic                  wrap_q, wrap_d;
  logic [CW-1:0]         scan_cnt_q, scan_cnt_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic [6:0]            seg_on_q, seg_on_d;
  logic [N_DIGITS-1:0]   an_on_q, an_on_d;
  logic                  inc_s;

  // Prescaler: advances only while enabled, emits inc on its terminal value.
  always_comb begin
    presc_d = presc_q;
    inc_s   = 1'b0;
    if (clr) begin
      presc_d = '0;
      inc_s   = en && (presc_q == PRESC_MAX);
    end else if (en) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        inc_s   = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end else begin
      presc_d = presc_q;
    end
  end

  // BCD ripple counter; clr wins over inc and suppresses the wrap pulse.
  always_comb begin : bcd_next
    logic       carry;
    logic       all_nines;
    logic [3:0] dig;
    count_d   = count_q;
    wrap_d    = 1'b0;
    carry     = inc_s;
    all_nines = 1'b1;
    for (int k = 0; k < N_DIGITS; k++) begin
      dig       = count_q[4*k +: 4];
      all_nines = all_nines && (dig == 4'd9);
      if (carry) begin
        if (dig == 4'd9) begin
          count_d[4*k +: 4] = 4'd0;
        end else begin
          count_d[4*k +: 4] = dig + 4'd1;
          carry             = 1'b0;
        end
      end else begin
        count_d[4*k +: 4] = dig;
      end
    end
    if (clr) begin
      count_d = '0;
      wrap_d  = 1'b0;
    end else if (inc_s) begin
      wrap_d  = all_nines;
    end else begin
      count_d = count_q;
      wrap_d  = 1'b0;
    end
  end

  // Free-running scan engine: dwell SCAN_DIV cycles per digit, then advance.
  always_comb begin
    scan_cnt_d = scan_cnt_q;
    sel_d      = sel_q;
    if (scan_cnt_q == SCAN_MAX) begin
      scan_cnt_d = '0;
      if (sel_q == SEL_MAX) begin
        sel_d = '0;
      end else begin
        sel_d = sel_q + 1'b1;
      end
    end else begin
      scan_cnt_d = scan_cnt_q + 1'b1;
      sel_d      = sel_q;
    end
  end

  // Decode the selected digit to strobe and segments, with leading-zero blanking.
  always_comb begin : decode_next
    logic                higher_zero;
    logic [N_DIGITS-1:0] blank;
    logic [3:0]          dig_sel;
    logic                blank_sel;
    higher_zero = 1'b1;
    blank       = '0;
    dig_sel     = 4'd0;
    blank_sel   = 1'b0;
    an_on_d     = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      higher_zero = higher_zero && (count_q[4*k +: 4] == 4'd0);
      blank[k]    = (LZ_BLANK != 0) && (k > 0) && higher_zero;
    end
    for (int k = 0; k < N_DIGITS; k++) begin
      if (sel_q == SW'(k)) begin
        an_on_d[k] = 1'b1;
        dig_sel    = count_q[4*k +: 4];
        blank_sel  = blank[k];
      end else begin
        an_on_d[k] = 1'b0;
      end
    end
    if (blank_sel) begin
      seg_on_d = 7'h00;
    end else begin
      seg_on_d = font(dig_sel);
    end
  end

  // State registers; reset leaves the display dark in either polarity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q    <= '0;
      count_q    <= '0;
      wrap_q     <= 1'b0;
      scan_cnt_q <= '0;
      sel_q      <= '0;
      seg_on_q   <= 7'h00;
      an_on_q    <= '0;
    end else begin
      presc_q    <= presc_d;
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      scan_cnt_q <= scan_cnt_d;
      sel_q      <= sel_d;
      seg_on_q   <= seg_on_d;
      an_on_q    <= an_on_d;
    end
  end

  // Pin polarity: CA inverts segments, CC inverts strobes; switches instantly.
  always_comb begin
    if (cathod_anode) begin
      seg = ~seg_on_q;
      an  = an_on_q;
    end else begin
      seg = seg_on_q;
      an  = ~an_on_q;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_sevenseg_bcd_scan_counter.sv
// Directed bench for sevenseg_bcd_scan_counter (2 digits, TICK_DIV=4,
// SCAN_DIV=2). A second instance with blanking disabled shares all inputs.
module tb_sevenseg_bcd_scan_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       ca = 1'b1;
  logic [6:0] seg0, seg1;
  logic [1:0] an0, an1;
  logic [7:0] count0, count1;
  logic       wrap0, wrap1;

  int total = 0;
  int bad = 0;

  sevenseg_bcd_scan_counter #(
    .N_DIGITS(2), .TICK_DIV(4), .SCAN_DIV(2), .LZ_BLANK(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .cathod_anode(ca),
    .seg(seg0), .an(an0), .count(count0), .wrap(wrap0)
  );

  sevenseg_bcd_scan_counter #(
    .N_DIGITS(2), .TICK_DIV(4), .SCAN_DIV(2), .LZ_BLANK(0)
  ) dut_nb (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .cathod_anode(ca),
    .seg(seg1), .an(an1), .count(count1), .wrap(wrap1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; clr = 1'b0; ca = 1'b1;
    #2;
    total++; if (seg0 !== 7'h7F) begin bad++; $display("FAIL reset_ca_seg got=%h want=7f", seg0); end
    total++; if (an0 !== 2'b00) begin bad++; $display("FAIL reset_ca_an got=%b want=00", an0); end
    total++; if (count0 !== 8'h00) begin bad++; $display("FAIL reset_count got=%h want=00", count0); end
    total++; if (wrap0 !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b want=0", wrap0); end
    ca = 1'b0;
    #1;
    total++; if (seg0 !== 7'h00) begin bad++; $display("FAIL reset_cc_seg got=%h want=00", seg0); end
    total++; if (an0 !== 2'b11) begin bad++; $display("FAIL reset_cc_an got=%b want=11", an0); end
    ca = 1'b1;
    step(1);
    rst = 1'b1;
  endtask

  task automatic test_count();
    int         ev;
    logic [7:0] expb;
    en = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      ev   = i / 4;
      expb = {4'(ev / 10), 4'(ev % 10)};
      total++;
      if (count0 !== expb) begin bad++; $display("FAIL count_cycle%0d got=%h want=%h", i, count0, expb); end
      total++;
      if (count0[3:0] > 4'd9 || count0[7:4] > 4'd9) begin
        bad++; $display("FAIL count_nibble cycle%0d got=%h want=bcd", i, count0);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_wrap();
    int wraps;
    clr = 1'b1; step(1); clr = 1'b0;
    en = 1'b1;
    step(396);
    total++; if (count0 !== 8'h99) begin bad++; $display("FAIL preload_99 got=%h want=99", count0); end
    total++; if (wrap0 !== 1'b0) begin bad++; $display("FAIL preload_wrap got=%b want=0", wrap0); end
    wraps = 0;
    for (int i = 1; i <= 5; i++) begin
      step(1);
      if (wrap0 === 1'b1) wraps++;
      if (i < 4) begin
        total++; if (count0 !== 8'h99) begin bad++; $display("FAIL wrap_hold%0d got=%h want=99", i, count0); end
        total++; if (wrap0 !== 1'b0) begin bad++; $display("FAIL wrap_early%0d got=%b want=0", i, wrap0); end
      end else if (i == 4) begin
        total++; if (count0 !== 8'h00) begin bad++; $display("FAIL wrap_count got=%h want=00", count0); end
        total++; if (wrap0 !== 1'b1) begin bad++; $display("FAIL wrap_pulse got=%b want=1", wrap0); end
      end else begin
        total++; if (count0 !== 8'h00) begin bad++; $display("FAIL wrap_after_count got=%h want=00", count0); end
        total++; if (wrap0 !== 1'b0) begin bad++; $display("FAIL wrap_after got=%b want=0", wrap0); end
      end
    end
    total++; if (wraps != 1) begin bad++; $display("FAIL wrap_once got=%0d want=1", wraps); end
    en = 1'b0;
  endtask

  task automatic test_blank();
    logic [1:0] prev_an, first_an, an_exp;
    logic [6:0] seg0_exp, seg1_exp;
    bit         found;
    clr = 1'b1; step(1); clr = 1'b0;
    en = 1'b1; step(20); en = 1'b0;
    ca = 1'b1;
    total++; if (count0 !== 8'h05) begin bad++; $display("FAIL blank_preload got=%h want=05", count0); end
    prev_an = an0;
    found = 1'b0;
    for (int t = 0; t < 8 && !found; t++) begin
      step(1);
      if (an0 !== prev_an) found = 1'b1;
      else prev_an = an0;
    end
    total++; if (!found) begin bad++; $display("FAIL scan_edge got=none want=an change"); end
    first_an = an0;
    total++;
    if (first_an !== 2'b01 && first_an !== 2'b10) begin
      bad++; $display("FAIL scan_onehot got=%b want=01|10", first_an);
    end
    for (int j = 0; j < 8; j++) begin
      if (j > 0) step(1);
      an_exp   = (((j / 2) % 2) == 0) ? first_an : ~first_an;
      seg0_exp = (an_exp == 2'b01) ? 7'h12 : 7'h7F;
      seg1_exp = (an_exp == 2'b01) ? 7'h12 : 7'h40;
      total++; if (an0 !== an_exp) begin bad++; $display("FAIL scan_an%0d got=%b want=%b", j, an0, an_exp); end
      total++; if (seg0 !== seg0_exp) begin bad++; $display("FAIL blank_seg%0d got=%h want=%h", j, seg0, seg0_exp); end
      total++; if (an1 !== an_exp) begin bad++; $display("FAIL nb_an%0d got=%b want=%b", j, an1, an_exp); end
      total++; if (seg1 !== seg1_exp) begin bad++; $display("FAIL noblank_seg%0d got=%h want=%h", j, seg1, seg1_exp); end
    end
  endtask

  task automatic test_hold_and_clr();
    logic [1:0] prev_an;
    int         toggles;
    en = 1'b1; step(2); en = 1'b0;
    toggles = 0;
    prev_an = an0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      total++; if (count0 !== 8'h05) begin bad++; $display("FAIL hold_count%0d got=%h want=05", i, count0); end
      if (an0 !== prev_an) toggles++;
      prev_an = an0;
    end
    total++; if (toggles < 20) begin bad++; $display("FAIL hold_scan got=%0d toggles want>=20", toggles); end
    en = 1'b1;
    step(1);
    total++; if (count0 !== 8'h05) begin bad++; $display("FAIL hold_presc3 got=%h want=05", count0); end
    step(1);
    total++; if (count0 !== 8'h06) begin bad++; $display("FAIL hold_resume got=%h want=06", count0); end
    step(3);
    total++; if (count0 !== 8'h06) begin bad++; $display("FAIL pre_clr got=%h want=06", count0); end
    clr = 1'b1; step(1); clr = 1'b0;
    total++; if (count0 !== 8'h00) begin bad++; $display("FAIL clr_inc_count got=%h want=00", count0); end
    total++; if (wrap0 !== 1'b0) begin bad++; $display("FAIL clr_inc_wrap got=%b want=0", wrap0); end
    clr = 1'b1; step(1); clr = 1'b0;
    step(399);
    total++; if (count0 !== 8'h99) begin bad++; $display("FAIL clr_wrap_preload got=%h want=99", count0); end
    clr = 1'b1; step(1); clr = 1'b0; en = 1'b0;
    total++; if (count0 !== 8'h00) begin bad++; $display("FAIL clr_wrap_count got=%h want=00", count0); end
    total++; if (wrap0 !== 1'b0) begin bad++; $display("FAIL clr_wrap_pulse got=%b want=0", wrap0); end
    step(1);
    total++; if (wrap0 !== 1'b0) begin bad++; $display("FAIL clr_wrap_late got=%b want=0", wrap0); end
    total++; if (count0 !== 8'h00) begin bad++; $display("FAIL clr_wrap_hold got=%h want=00", count0); end
  endtask

  task automatic test_async_reset();
    clr = 1'b1; step(1); clr = 1'b0;
    en = 1'b1; step(148); en = 1'b0;
    ca = 1'b1;
    total++; if (count0 !== 8'h37) begin bad++; $display("FAIL async_preload got=%h want=37", count0); end
    #3;
    rst = 1'b0;
    #1;
    total++; if (count0 !== 8'h00) begin bad++; $display("FAIL async_count got=%h want=00", count0); end
    total++; if (seg0 !== 7'h7F) begin bad++; $display("FAIL async_seg got=%h want=7f", seg0); end
    total++; if (an0 !== 2'b00) begin bad++; $display("FAIL async_an got=%b want=00", an0); end
    total++; if (wrap0 !== 1'b0) begin bad++; $display("FAIL async_wrap got=%b want=0", wrap0); end
    step(1);
    rst = 1'b1;
    en = 1'b1;
    step(3);
    total++; if (count0 !== 8'h00) begin bad++; $display("FAIL restart_early got=%h want=00", count0); end
    step(1);
    total++; if (count0 !== 8'h01) begin bad++; $display("FAIL restart_first got=%h want=01", count0); end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_blank();
    test_hold_and_clr();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
